// File: rtl/veda_mem_sequencer_if.sv
// Bundles the command, response and memory-side signals of veda_mem_sequencer.
// The sequencer connects through the slave modport; the driving environment uses master.
interface veda_mem_sequencer_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic [AW-1:0] mem_address_a;
  logic [AW-1:0] mem_address_b;
  logic [DW-1:0] mem_data_in;
  logic          mem_write_enable;
  logic          mem_mode;
  logic [DW-1:0] mem_data_out;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, mem_data_out,
    input  cmd_ready, rsp_valid, rsp_data,
           mem_address_a, mem_address_b, mem_data_in, mem_write_enable, mem_mode
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, rsp_ready, mem_data_out,
    output cmd_ready, rsp_valid, rsp_data,
           mem_address_a, mem_address_b, mem_data_in, mem_write_enable, mem_mode
  );
endinterface

// File: rtl/veda_mem_sequencer.sv
// In-order command sequencer for the 32x32 Veda memory: FIFO-buffered read/write
// commands, single-cycle registered memory accesses, and a valid/ready read response.
module veda_mem_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  veda_mem_sequencer_if.slave bus,
  output logic                busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = 1 + AW + DW;
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [AW-1:0] IDLE_B   = AW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t state, state_n;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  logic          head_write;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  logic [AW-1:0] mem_a_q, mem_a_n;
  logic [AW-1:0] mem_b_q, mem_b_n;
  logic [DW-1:0] mem_din_q, mem_din_n;
  logic          mem_we_q, mem_we_n;
  logic          mem_mode_q, mem_mode_n;
  logic          rsp_valid_q, rsp_valid_n;
  logic [DW-1:0] rsp_data_q, rsp_data_n;

  assign bus.cmd_ready = (count != FULL_CNT);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign {head_write, head_addr, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_a_q     <= '0;
      mem_b_q     <= IDLE_B;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_n;
      mem_a_q     <= mem_a_n;
      mem_b_q     <= mem_b_n;
      mem_din_q   <= mem_din_n;
      mem_we_q    <= mem_we_n;
      mem_mode_q  <= mem_mode_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
    end
  end

  // Memory outputs default to idle every cycle; only the IDLE->ISSUE transition
  // loads a command, so ISSUE lasts exactly one cycle. The unused port always
  // gets addr^1 so the memory never sees equal addresses and suppresses nothing.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    mem_a_n     = '0;
    mem_b_n     = IDLE_B;
    mem_din_n   = '0;
    mem_we_n    = 1'b0;
    mem_mode_n  = 1'b0;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = ISSUE;
          if (head_write) begin
            mem_a_n   = head_addr;
            mem_b_n   = head_addr ^ IDLE_B;
            mem_din_n = head_data;
            mem_we_n  = 1'b1;
          end else begin
            mem_mode_n = 1'b1;
            mem_b_n    = head_addr;
            mem_a_n    = head_addr ^ IDLE_B;
          end
        end
      end
      ISSUE:   state_n = mem_mode_q ? CAPTURE : IDLE;
      CAPTURE: begin
        rsp_data_n  = bus.mem_data_out;
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_address_a    = mem_a_q;
  assign bus.mem_address_b    = mem_b_q;
  assign bus.mem_data_in      = mem_din_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_mode         = mem_mode_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;

  assign busy = (state != IDLE) || (count != '0);
endmodule
